// File: rtl/apx_float_addsub.sv
// Purpose    : approximate IEEE-754 single add/sub; the low n = min(apx_bits, MAX_NAB) mantissa bits are zeroed.
// Latency    : 9 cycles from B accepted to output_z_stb when no align/normalise shifts; specials take 2.
// Backpressure: stb/ack on every port; the result is held on output_z until output_z_ack, and A/B are not accepted meanwhile.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   input_a/_stb/_ack, op, apx_bits  operand A with opcode (0 add, 1 sub) and approximation count
//   input_b/_stb/_ack                operand B
//   output_z/_stb/_ack               result
// Optional feature: define APX_FLOAT_ROUND_EN for round-to-nearest-even at kept LSB n;
// without it the ROUND state is a one-cycle pass-through (truncation).
module apx_float_addsub #(
   parameter int MAX_NAB = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   input  logic        op,
   input  logic [4:0]  apx_bits,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   typedef enum logic [3:0] {
      GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1,
      NORM_1, NORM_2, ROUND, PACK, PUT_Z
   } state_t;

   localparam logic [4:0]  MAX_N   = 5'(MAX_NAB);
   localparam logic [31:0] QNAN    = 32'hFFC0_0000;
   localparam logic signed [9:0] EMIN  = -10'sd126;
   localparam logic signed [9:0] EMAX  = 10'sd127;

   state_t state, state_nxt;

   logic [31:0]        a, b, z;
   logic               op_q;
   logic [4:0]         n_q;
   logic [26:0]        a_m, b_m;      // hidden bit, 23 fraction bits, 3 guard bits
   logic signed [9:0]  a_e, b_e, z_e;
   logic               a_s, b_s, z_s;
   logic [27:0]        sum;
   logic [23:0]        z_m;
   logic               guard, round_bit, sticky;
   logic               a_ack_q, b_ack_q, z_stb_q;

   logic [4:0]         n_eff;
   logic [22:0]        keep_mask;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_special;
   logic               norm1_shift, norm2_shift;
   logic [7:0]         z_exp_b;
   logic [31:0]        pack_z;

   // Oversized requests saturate at MAX_NAB rather than wrapping.
   assign n_eff     = (apx_bits > MAX_N) ? MAX_N : apx_bits;
   assign keep_mask = 23'h7F_FFFF << n_q;

   // Classification runs on the truncated mantissas, so a denormal whose
   // surviving bits are all zeroed is treated as zero.
   assign a_nan  = (a[30:23] == 8'hFF) && (a_m[25:3] != 23'd0);
   assign b_nan  = (b[30:23] == 8'hFF) && (b_m[25:3] != 23'd0);
   assign a_inf  = (a[30:23] == 8'hFF) && (a_m[25:3] == 23'd0);
   assign b_inf  = (b[30:23] == 8'hFF) && (b_m[25:3] == 23'd0);
   assign a_zero = (a[30:23] == 8'h00) && (a_m[25:3] == 23'd0);
   assign b_zero = (b[30:23] == 8'h00) && (b_m[25:3] == 23'd0);
   assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

   assign norm1_shift = !z_m[23] && (z_e > EMIN);
   assign norm2_shift = (z_e < EMIN);

   assign z_exp_b = z_e[7:0] + 8'd127;

   always_comb begin
      pack_z = {z_s, z_exp_b, z_m[22:0] & keep_mask};
      if ((z_e == EMIN) && !z_m[23]) begin
         pack_z[30:23] = 8'h00;
      end
      if (z_e > EMAX) begin
         pack_z = {z_s, 8'hFF, 23'd0};
      end
   end

`ifdef APX_FLOAT_ROUND_EN
   // Extended view {z_m, guard, round, sticky}: kept LSB sits at n+3, the
   // half-ulp bit at n+2, everything below it is the tie breaker.
   logic [26:0] rnd_ext, rnd_low;
   logic        rnd_inc;
   logic [24:0] rnd_sum;

   always_comb begin
      rnd_ext = {z_m, guard, round_bit, sticky};
      rnd_low = (27'd1 << (n_q + 5'd2)) - 27'd1;
      rnd_inc = rnd_ext[n_q + 5'd2] &&
                (((rnd_ext & rnd_low) != 27'd0) || rnd_ext[n_q + 5'd3]);
      rnd_sum = {1'b0, z_m} + (25'd1 << n_q);
   end
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= GET_A;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         GET_A:   if (a_ack_q && input_a_stb) state_nxt = GET_B;
         GET_B:   if (b_ack_q && input_b_stb) state_nxt = UNPACK;
         UNPACK:  state_nxt = SPECIAL;
         SPECIAL: state_nxt = is_special ? PUT_Z : ALIGN;
         ALIGN:   if (a_e == b_e) state_nxt = ADD_0;
         ADD_0:   state_nxt = ADD_1;
         ADD_1:   state_nxt = NORM_1;
         NORM_1:  if (!norm1_shift) state_nxt = NORM_2;
         NORM_2:  if (!norm2_shift) state_nxt = ROUND;
         ROUND:   state_nxt = PACK;
         PACK:    state_nxt = PUT_Z;
         PUT_Z:   if (z_stb_q && output_z_ack) state_nxt = GET_A;
         default: state_nxt = GET_A;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a         <= '0;
         b         <= '0;
         z         <= '0;
         op_q      <= 1'b0;
         n_q       <= '0;
         a_m       <= '0;
         b_m       <= '0;
         a_e       <= '0;
         b_e       <= '0;
         z_e       <= '0;
         a_s       <= 1'b0;
         b_s       <= 1'b0;
         z_s       <= 1'b0;
         sum       <= '0;
         z_m       <= '0;
         guard     <= 1'b0;
         round_bit <= 1'b0;
         sticky    <= 1'b0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         z_stb_q   <= 1'b0;
      end else begin
         // Handshake outputs are registered from the next state so they
         // drop in the cycle after the transfer.
         a_ack_q <= (state_nxt == GET_A);
         b_ack_q <= (state_nxt == GET_B);
         z_stb_q <= (state_nxt == PUT_Z);

         case (state)
            GET_A: begin
               if (a_ack_q && input_a_stb) begin
                  a    <= input_a;
                  op_q <= op;
                  n_q  <= n_eff;
               end
            end
            GET_B: begin
               if (b_ack_q && input_b_stb) begin
                  b <= input_b;
               end
            end
            UNPACK: begin
               a_m <= {1'b0, a[22:0] & keep_mask, 3'b000};
               b_m <= {1'b0, b[22:0] & keep_mask, 3'b000};
               a_e <= $signed({2'b00, a[30:23]}) - 10'sd127;
               b_e <= $signed({2'b00, b[30:23]}) - 10'sd127;
               a_s <= a[31];
               b_s <= b[31] ^ op_q;      // subtraction is addition of -B
            end
            SPECIAL: begin
               if (a_nan || b_nan) begin
                  z <= QNAN;
               end else if (a_inf) begin
                  z <= (b_inf && (a_s != b_s)) ? QNAN : {a_s, 8'hFF, 23'd0};
               end else if (b_inf) begin
                  z <= {b_s, 8'hFF, 23'd0};
               end else if (a_zero && b_zero) begin
                  z <= {a_s & b_s, 31'd0};
               end else if (a_zero) begin
                  z <= {b_s, b[30:23], b_m[25:3]};
               end else if (b_zero) begin
                  z <= {a_s, a[30:23], a_m[25:3]};
               end else begin
                  if (a[30:23] == 8'h00) a_e <= EMIN;
                  else                   a_m[26] <= 1'b1;
                  if (b[30:23] == 8'h00) b_e <= EMIN;
                  else                   b_m[26] <= 1'b1;
               end
            end
            ALIGN: begin
               // Shifted-out bits collapse into bit 0 as a sticky flag.
               if (a_e > b_e) begin
                  b_e <= b_e + 10'sd1;
                  b_m <= {1'b0, b_m[26:2], b_m[1] | b_m[0]};
               end else if (a_e < b_e) begin
                  a_e <= a_e + 10'sd1;
                  a_m <= {1'b0, a_m[26:2], a_m[1] | a_m[0]};
               end
            end
            ADD_0: begin
               z_e <= a_e;
               if (a_s == b_s) begin
                  sum <= {1'b0, a_m} + {1'b0, b_m};
                  z_s <= a_s;
               end else if (a_m > b_m) begin
                  sum <= {1'b0, a_m} - {1'b0, b_m};
                  z_s <= a_s;
               end else if (b_m > a_m) begin
                  sum <= {1'b0, b_m} - {1'b0, a_m};
                  z_s <= b_s;
               end else begin
                  sum <= '0;
                  z_s <= 1'b0;           // exact cancellation is +0
               end
            end
            ADD_1: begin
               if (sum[27]) begin
                  z_m       <= sum[27:4];
                  guard     <= sum[3];
                  round_bit <= sum[2];
                  sticky    <= sum[1] | sum[0];
                  z_e       <= z_e + 10'sd1;
               end else begin
                  z_m       <= sum[26:3];
                  guard     <= sum[2];
                  round_bit <= sum[1];
                  sticky    <= sum[0];
               end
            end
            NORM_1: begin
               if (norm1_shift) begin
                  z_e       <= z_e - 10'sd1;
                  z_m       <= {z_m[22:0], guard};
                  guard     <= round_bit;
                  round_bit <= 1'b0;
               end
            end
            NORM_2: begin
               if (norm2_shift) begin
                  z_e       <= z_e + 10'sd1;
                  z_m       <= {1'b0, z_m[23:1]};
                  guard     <= z_m[0];
                  round_bit <= guard;
                  sticky    <= sticky | round_bit;
               end
            end
            ROUND: begin
`ifdef APX_FLOAT_ROUND_EN
               if (rnd_inc) begin
                  if (rnd_sum[24]) begin
                     z_m <= rnd_sum[24:1];
                     z_e <= z_e + 10'sd1;
                  end else begin
                     z_m <= rnd_sum[23:0];
                  end
               end
`else
               // Truncation: the mantissa passes through unchanged.
`endif
            end
            PACK: begin
               z <= pack_z;
            end
            default: begin
            end
         endcase
      end
   end

   assign input_a_ack  = a_ack_q;
   assign input_b_ack  = b_ack_q;
   assign output_z_stb = z_stb_q;
   assign output_z     = z;

endmodule

// File: tb/tb_apx_float_addsub.sv
// Purpose    : randomized and directed check of apx_float_addsub (default truncating build).
// Latency    : waits on each handshake with a bounded cycle budget.
// Backpressure: holds output_z_ack low for a chosen number of cycles on some results.
module tb_apx_float_addsub;

   localparam int MAXN     = 16;
   localparam int WAIT_MAX = 2000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] input_a, input_b;
   logic        input_a_stb, input_b_stb;
   logic        input_a_ack, input_b_ack;
   logic        op;
   logic [4:0]  apx_bits;
   logic [31:0] output_z;
   logic        output_z_stb, output_z_ack;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   apx_float_addsub #(.MAX_NAB(MAXN)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .input_b      (input_b),
      .input_b_stb  (input_b_stb),
      .input_b_ack  (input_b_ack),
      .op           (op),
      .apx_bits     (apx_bits),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Exact value arithmetic on integers: both significands are placed on a
   // common scale with 39 extra low bits. If the smaller operand falls below
   // that scale it only matters as "something nonzero", so a single 1 stands in.
   function automatic logic [31:0] ref_addsub(input logic [31:0] a, input logic [31:0] b,
                                              input logic o, input logic [4:0] apx);
      int n, ea, eb, xa, xb, xh, xl, d, p, e, sft;
      logic [22:0] keep;
      logic sa, sb, sh, sl, s;
      longint unsigned fa, fb, ma, mb, mh, ml, H, L, M, sig;
      n    = (int'(apx) > MAXN) ? MAXN : int'(apx);
      keep = 23'h7F_FFFF << n;
      sa = a[31];
      sb = b[31] ^ o;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      fa = 64'(a[22:0] & keep);
      fb = 64'(b[22:0] & keep);
      if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 32'hFFC0_0000;
      if (ea == 255) return (eb == 255 && sa != sb) ? 32'hFFC0_0000 : {sa, 8'hFF, 23'd0};
      if (eb == 255) return {sb, 8'hFF, 23'd0};
      if (ea == 0 && fa == 0 && eb == 0 && fb == 0) return {sa & sb, 31'd0};
      if (ea == 0 && fa == 0) return {sb, b[30:23], fb[22:0]};
      if (eb == 0 && fb == 0) return {sa, a[30:23], fa[22:0]};
      ma = (ea == 0) ? fa : (fa | (64'd1 << 23));
      mb = (eb == 0) ? fb : (fb | (64'd1 << 23));
      xa = (ea == 0) ? 1 : ea;
      xb = (eb == 0) ? 1 : eb;
      if (xa >= xb) begin
         mh = ma; xh = xa; sh = sa; ml = mb; xl = xb; sl = sb;
      end else begin
         mh = mb; xh = xb; sh = sb; ml = ma; xl = xa; sl = sa;
      end
      d = xh - xl;
      H = mh << 39;
      L = (ml << 39) >> d;
      if ((L << d) != (ml << 39)) L = L | 64'd1;
      if (sh == sl) begin
         M = H + L; s = sh;
      end else if (H > L) begin
         M = H - L; s = sh;
      end else if (L > H) begin
         M = L - H; s = sl;
      end else begin
         return 32'h0000_0000;
      end
      p = 0;
      for (int i = 0; i < 64; i++) if (M[i]) p = i;
      e = xh + p - 62;
      if (e < 1) e = 1;
      if (e >= 255) return {s, 8'hFF, 23'd0};
      sft = e - xh + 39;
      sig = (sft >= 0) ? (M >> sft) : (M << (-sft));
      return {s, (sig[23] ? 8'(e) : 8'd0), sig[22:0] & keep};
   endfunction

   task automatic send_a(input logic [31:0] a, input logic o, input logic [4:0] apx);
      int cnt = 0;
      @(negedge clk);
      input_a = a; op = o; apx_bits = apx; input_a_stb = 1'b1;
      while (!input_a_ack && cnt < WAIT_MAX) begin
         @(negedge clk);
         cnt++;
      end
      if (!input_a_ack) check("a_ack_timeout", {31'd0, input_a_ack}, 32'd1);
      @(negedge clk);
      input_a_stb = 1'b0;
      input_a     = $urandom;            // A-side inputs must be ignored from here on
      op          = 1'($urandom);
      apx_bits    = 5'($urandom);
   endtask

   task automatic send_b(input logic [31:0] b);
      int cnt = 0;
      input_b = b; input_b_stb = 1'b1;
      while (!input_b_ack && cnt < WAIT_MAX) begin
         @(negedge clk);
         cnt++;
      end
      if (!input_b_ack) check("b_ack_timeout", {31'd0, input_b_ack}, 32'd1);
      @(negedge clk);
      input_b_stb = 1'b0;
      input_b     = $urandom;
   endtask

   // Called at the first negedge after B was accepted, so lat counts clock
   // edges from acceptance to output_z_stb.
   task automatic get_z(input string tag, input logic [31:0] exp, input int hold, output int lat);
      lat = 0;
      while (!output_z_stb && lat < WAIT_MAX) begin
         @(negedge clk);
         lat++;
      end
      if (!output_z_stb) check("z_stb_timeout", {31'd0, output_z_stb}, 32'd1);
      for (int i = 0; i < hold; i++) begin
         check("stall_stb", {31'd0, output_z_stb}, 32'd1);
         check("stall_z", output_z, exp);
         @(negedge clk);
      end
      check(tag, output_z, exp);
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = 1'b0;
      check("z_stb_drop", {31'd0, output_z_stb}, 32'd0);
   endtask

   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input logic [4:0] apx, input logic [31:0] exp,
                        input int hold, output int lat);
      send_a(a, o, apx);
      send_b(b);
      get_z(tag, exp, hold, lat);
   endtask

   function automatic logic [31:0] rnd_operand(input int e);
      logic [31:0] v;
      case ($urandom_range(0, 11))
         0:       v = {1'($urandom), 31'd0};
         1:       v = {1'($urandom), 8'hFF, 23'd0};
         2:       v = {1'($urandom), 8'h00, 23'($urandom)};
         3:       v = 32'h7FC0_0000;
         default: v = {1'($urandom), 8'(e), 23'($urandom)};
      endcase
      return v;
   endfunction

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        o;
      logic [4:0]  apx;
      logic [31:0] exp;
   } vec_t;

   vec_t dir_tab[$] = '{
      '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 5'd0,  32'h4000_0000},
      '{32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd0,  32'h4040_0000},
      '{32'h4040_0000, 32'h3F80_0000, 1'b1, 5'd0,  32'h4000_0000},
      '{32'h3F80_0000, 32'h3F80_0000, 1'b1, 5'd0,  32'h0000_0000},
      '{32'h3F80_0000, 32'h4000_0000, 1'b1, 5'd0,  32'hBF80_0000},
      '{32'h3F80_00FF, 32'h3F80_0000, 1'b0, 5'd8,  32'h4000_0000},
      '{32'h3F81_0000, 32'h3F81_0000, 1'b0, 5'd31, 32'h4001_0000},
      '{32'h3F80_8000, 32'h3F80_8000, 1'b0, 5'd31, 32'h4000_0000},
      '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 5'd0,  32'hFFC0_0000},
      '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 5'd0,  32'h7F80_0000},
      '{32'h7FC0_0000, 32'h3F80_0000, 1'b0, 5'd0,  32'hFFC0_0000},
      '{32'h3F80_0000, 32'h7F80_0000, 1'b1, 5'd0,  32'hFF80_0000},
      '{32'h8000_0000, 32'h8000_0000, 1'b0, 5'd0,  32'h8000_0000},
      '{32'h0000_0000, 32'h0000_0000, 1'b1, 5'd0,  32'h0000_0000},
      '{32'h0000_0000, 32'h3F80_0000, 1'b1, 5'd0,  32'hBF80_0000},
      '{32'h0000_0001, 32'h0000_0001, 1'b0, 5'd0,  32'h0000_0002},
      '{32'h0080_0000, 32'h0000_0001, 1'b1, 5'd0,  32'h007F_FFFF},
      '{32'h3F80_0000, 32'hBF80_0000, 1'b0, 5'd0,  32'h0000_0000},
      '{32'hBF80_0000, 32'hBF80_0000, 1'b1, 5'd0,  32'h0000_0000}
   };

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int ea, eb;
      logic [31:0] a, b, exp;
      logic o;
      logic [4:0] apx;

      rst_n = 1'b0;
      input_a = '0; input_b = '0; input_a_stb = 1'b0; input_b_stb = 1'b0;
      op = 1'b0; apx_bits = '0; output_z_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_hs", {29'd0, input_a_ack, input_b_ack, output_z_stb}, 32'd0);
      check("rst_z", output_z, 32'd0);
      rst_n = 1'b1;

      // Directed vectors; the first one has equal exponents and no shifts.
      foreach (dir_tab[i]) begin
         do_op($sformatf("dir%0d", i), dir_tab[i].a, dir_tab[i].b, dir_tab[i].o,
               dir_tab[i].apx, dir_tab[i].exp, 0, lat);
         if (i == 0) begin
            check("min_latency", 32'(lat), 32'd9);
            check("a_ack_after_z", {31'd0, input_a_ack}, 32'd1);
         end
      end

      // Result held for 10 cycles without ack.
      do_op("stall_res", 32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd0, 32'h4040_0000, 10, lat);

      // Reset in the middle of a 31-step alignment, then a fresh pair.
      send_a(32'h3F80_0000, 1'b0, 5'd0);
      send_b(32'h3000_0000);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_hs", {29'd0, input_a_ack, input_b_ack, output_z_stb}, 32'd0);
      check("midrst_z", output_z, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("after_rst", 32'h4040_0000, 32'h3F80_0000, 1'b1, 5'd0, 32'h4000_0000, 0, lat);

      // Randomized pairs against the integer-arithmetic model.
      for (int k = 0; k < 150; k++) begin
         ea = $urandom_range(0, 254);
         if ($urandom_range(0, 3) == 0) begin
            eb = $urandom_range(0, 254);
         end else begin
            eb = ea + $urandom_range(0, 6) - 3;
            if (eb < 0)   eb = 0;
            if (eb > 254) eb = 254;
         end
         a   = rnd_operand(ea);
         b   = ($urandom_range(0, 7) == 0) ? a : rnd_operand(eb);
         o   = 1'($urandom);
         apx = 5'($urandom_range(0, 31));
         exp = ref_addsub(a, b, o, apx);
         do_op($sformatf("rnd%0d a=%08h b=%08h op=%0d apx=%0d", k, a, b, o, apx),
               a, b, o, apx, exp, $urandom_range(0, 1), lat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
